// File: rtl/ft245_packetizer.sv
// ft245_packetizer
//   Buffers FFT output words and streams each FFT_N-word block to an FT245
//   sync-FIFO bridge as START_FLAG, data bytes (MSB byte of each word first),
//   STOP_FLAG. Honours txe_n back-pressure with registered wr_n/ft_data.
//   ft245_empty tells the sequencer that nothing is buffered or in flight.
//
//   Optional build macro: FT245_CHECKSUM_EN
//     When defined, a CSUM byte (XOR of every data byte of the frame) is
//     inserted between the last data byte and STOP_FLAG.
//
//   Reset is synchronous and active-low (rst_n). Buffer contents are not
//   reset; only pointers and counters are, so a reset discards everything.

module ft245_packetizer #(
   parameter int         DW         = 32,
   parameter int         FFT_N      = 1024,
   parameter int         FIFO_LG_N  = 10,
   parameter logic [7:0] START_FLAG = 8'h5A,
   parameter logic [7:0] STOP_FLAG  = 8'hA5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          txe_n,
   output logic          wr_n,
   output logic [7:0]    ft_data,
   output logic          ft245_empty,
   output logic          overflow
);

   localparam int NB    = DW / 8;
   localparam int DEPTH = 1 << FIFO_LG_N;
   localparam int WCW   = (FFT_N > 1) ? $clog2(FFT_N) : 1;
   localparam int BCW   = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [FIFO_LG_N:0] DEPTH_C     = (FIFO_LG_N+1)'(DEPTH);
   localparam logic [WCW-1:0]     WORD_LAST_C = WCW'(FFT_N - 1);
   localparam logic [BCW-1:0]     BYTE_LAST_C = BCW'(NB - 1);

`ifdef FT245_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_LOAD = 3'd3,
      ST_CSUM = 3'd4,
      ST_TRL  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_LOAD = 3'd3,
      ST_TRL  = 3'd5
   } state_t;
`endif

   // Word buffer
   logic [DW-1:0]        mem_r [0:DEPTH-1];
   logic [FIFO_LG_N-1:0] wr_ptr_r;
   logic [FIFO_LG_N-1:0] rd_ptr_r;
   logic [FIFO_LG_N:0]   count_r;
   logic                 overflow_r;

   // Framer
   state_t               state_r;
   logic [DW-1:0]        shift_r;
   logic [BCW-1:0]       byte_cnt_r;
   logic [WCW-1:0]       word_cnt_r;
   logic                 wr_n_r;
   logic [7:0]           ft_data_r;
   logic                 empty_r;
`ifdef FT245_CHECKSUM_EN
   logic [7:0]           csum_r;
`endif

   // Handshake / control
   logic                 full_s;
   logic                 buf_empty_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 accept_s;
   logic                 byte_last_s;
   logic                 word_last_s;
   logic [DW-1:0]        head_word_s;

   assign full_s      = (count_r == DEPTH_C);
   assign buf_empty_s = (count_r == '0);
   assign push_s      = in_valid && !full_s;
   assign accept_s    = !wr_n_r && !txe_n;
   assign byte_last_s = (byte_cnt_r == BYTE_LAST_C);
   assign word_last_s = (word_cnt_r == WORD_LAST_C);
   assign head_word_s = mem_r[rd_ptr_r];

   // Decide when the framer consumes the head word of the buffer
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_HDR: begin
            if (accept_s && !buf_empty_s) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         ST_DATA: begin
            if (accept_s && byte_last_s && !word_last_s && !buf_empty_s) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         ST_LOAD: begin
            if (!buf_empty_s) begin
               pop_s = 1'b1;
            end else begin
               pop_s = 1'b0;
            end
         end
         default: begin
            pop_s = 1'b0;
         end
      endcase
   end

   // Buffer storage; written only on accepted pushes, never reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Buffer pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + FIFO_LG_N'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + FIFO_LG_N'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (FIFO_LG_N+1)'(1);
            2'b01:   count_r <= count_r - (FIFO_LG_N+1)'(1);
            default: count_r <= count_r;
         endcase
         if (in_valid && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Frame FSM: every transition past IDLE/LOAD is gated by a byte accept
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         shift_r    <= '0;
         byte_cnt_r <= '0;
         word_cnt_r <= '0;
         wr_n_r     <= 1'b1;
         ft_data_r  <= 8'h00;
`ifdef FT245_CHECKSUM_EN
         csum_r     <= 8'h00;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!buf_empty_s) begin
                  state_r   <= ST_HDR;
                  ft_data_r <= START_FLAG;
                  wr_n_r    <= 1'b0;
               end
            end
            ST_HDR: begin
               if (accept_s) begin
                  byte_cnt_r <= '0;
                  word_cnt_r <= '0;
`ifdef FT245_CHECKSUM_EN
                  csum_r     <= 8'h00;
`endif
                  if (pop_s) begin
                     ft_data_r <= head_word_s[DW-1 -: 8];
                     shift_r   <= head_word_s << 8;
                     state_r   <= ST_DATA;
                  end else begin
                     wr_n_r  <= 1'b1;
                     state_r <= ST_LOAD;
                  end
               end
            end
            ST_DATA: begin
               if (accept_s) begin
`ifdef FT245_CHECKSUM_EN
                  csum_r <= csum_r ^ ft_data_r;
`endif
                  if (!byte_last_s) begin
                     ft_data_r  <= shift_r[DW-1 -: 8];
                     shift_r    <= shift_r << 8;
                     byte_cnt_r <= byte_cnt_r + BCW'(1);
                  end else if (word_last_s) begin
                     byte_cnt_r <= '0;
                     word_cnt_r <= '0;
`ifdef FT245_CHECKSUM_EN
                     ft_data_r  <= csum_r ^ ft_data_r;
                     state_r    <= ST_CSUM;
`else
                     ft_data_r  <= STOP_FLAG;
                     state_r    <= ST_TRL;
`endif
                  end else begin
                     byte_cnt_r <= '0;
                     word_cnt_r <= word_cnt_r + WCW'(1);
                     if (pop_s) begin
                        ft_data_r <= head_word_s[DW-1 -: 8];
                        shift_r   <= head_word_s << 8;
                     end else begin
                        wr_n_r  <= 1'b1;
                        state_r <= ST_LOAD;
                     end
                  end
               end
            end
            ST_LOAD: begin
               // Starved mid-frame: wait with wr_n high for the next word
               if (pop_s) begin
                  ft_data_r <= head_word_s[DW-1 -: 8];
                  shift_r   <= head_word_s << 8;
                  wr_n_r    <= 1'b0;
                  state_r   <= ST_DATA;
               end
            end
`ifdef FT245_CHECKSUM_EN
            ST_CSUM: begin
               if (accept_s) begin
                  ft_data_r <= STOP_FLAG;
                  state_r   <= ST_TRL;
               end
            end
`endif
            ST_TRL: begin
               if (accept_s) begin
                  wr_n_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               wr_n_r  <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Idle status for the sequencer: nothing buffered and nothing on the bus
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         empty_r <= 1'b1;
      end else begin
         empty_r <= buf_empty_s && (state_r == ST_IDLE) && wr_n_r;
      end
   end

   assign wr_n        = wr_n_r;
   assign ft_data     = ft_data_r;
   assign ft245_empty = empty_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_ft245_packetizer.sv
// Directed bench for ft245_packetizer with DW=16, FFT_N=4, FIFO_LG_N=2.
// A negedge monitor records every byte the bridge would accept; each test
// compares that stream and key status outputs against hand-computed values.

module tb_ft245_packetizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        txe_n;
   logic        wr_n;
   logic [7:0]  ft_data;
   logic        ft245_empty;
   logic        overflow;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   ft245_packetizer #(
      .DW        (16),
      .FFT_N     (4),
      .FIFO_LG_N (2),
      .START_FLAG(8'h5A),
      .STOP_FLAG (8'hA5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .txe_n      (txe_n),
      .wr_n       (wr_n),
      .ft_data    (ft_data),
      .ft245_empty(ft245_empty),
      .overflow   (overflow)
   );

   // Record bytes that the coming rising edge will accept
   always @(negedge clk) begin
      if (rst_n && !wr_n && !txe_n) got_q.push_back(ft_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'h0000;
      txe_n    = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      got_q.delete();
   endtask

   task automatic push_word(input logic [15:0] w);
      in_valid = 1'b1;
      in_data  = w;
      step();
      in_valid = 1'b0;
   endtask

   task automatic push_frame();
      push_word(16'h0102);
      push_word(16'h0304);
      push_word(16'h0506);
      push_word(16'h0708);
   endtask

   task automatic build_exp();
      exp_q = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef FT245_CHECKSUM_EN
      exp_q.push_back(8'h08);
`endif
      exp_q.push_back(8'hA5);
   endtask

   task automatic wait_bytes(input int n, input string name);
      int i;
      for (i = 0; i < 400 && got_q.size() < n; i++) step();
      n_checks++;
      if (got_q.size() < n)
         $display("FAIL %s_timeout: got %0d bytes, need %0d", name, got_q.size(), n);
      else
         n_pass++;
   endtask

   task automatic check_frame(input string name);
      wait_bytes(exp_q.size(), name);
      step();
      step();
      step();
      n_checks++;
      if (got_q.size() !== exp_q.size())
         $display("FAIL %s_len: got %0d bytes, expected %0d", name, got_q.size(), exp_q.size());
      else
         n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         logic [7:0] g;
         g = (i < got_q.size()) ? got_q[i] : 8'hxx;
         n_checks++;
         if (g !== exp_q[i])
            $display("FAIL %s_byte%0d: got %h, expected %h", name, i, g, exp_q[i]);
         else
            n_pass++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({wr_n, ft_data, ft245_empty, overflow} !== {1'b1, 8'h00, 1'b1, 1'b0})
         $display("FAIL reset_vals: got wr_n=%b ft_data=%h empty=%b ovf=%b, expected 1 00 1 0",
                  wr_n, ft_data, ft245_empty, overflow);
      else
         n_pass++;
   endtask

   task automatic test_basic();
      do_reset();
      txe_n = 1'b0;
      push_word(16'h0102);
      n_checks++;
      if ({wr_n, ft245_empty} !== 2'b11)
         $display("FAIL basic_pre_hdr: got wr_n=%b empty=%b, expected 1 1", wr_n, ft245_empty);
      else
         n_pass++;
      push_word(16'h0304);
      n_checks++;
      if ({wr_n, ft_data, ft245_empty} !== {1'b0, 8'h5A, 1'b0})
         $display("FAIL basic_hdr: got wr_n=%b ft_data=%h empty=%b, expected 0 5a 0",
                  wr_n, ft_data, ft245_empty);
      else
         n_pass++;
      push_word(16'h0506);
      push_word(16'h0708);
      check_frame("basic");
      n_checks++;
      if ({wr_n, ft245_empty} !== 2'b11)
         $display("FAIL basic_end_empty: got wr_n=%b empty=%b, expected 1 1", wr_n, ft245_empty);
      else
         n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      txe_n = 1'b0;
      push_frame();
      wait_bytes(4, "stall_pre");
      txe_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if ({wr_n, ft_data} !== {1'b0, 8'h04})
            $display("FAIL stall_hold%0d: got wr_n=%b ft_data=%h, expected 0 04", i, wr_n, ft_data);
         else
            n_pass++;
      end
      n_checks++;
      if (got_q.size() !== 4)
         $display("FAIL stall_count: got %0d bytes during stall, expected 4", got_q.size());
      else
         n_pass++;
      txe_n = 1'b0;
      check_frame("stall");
   endtask

   task automatic test_overflow();
      do_reset();
      push_frame();
      n_checks++;
      if (overflow !== 1'b0)
         $display("FAIL ovf_before: got %b, expected 0", overflow);
      else
         n_pass++;
      push_word(16'hDEAD);
      n_checks++;
      if (overflow !== 1'b1)
         $display("FAIL ovf_set: got %b, expected 1", overflow);
      else
         n_pass++;
      txe_n = 1'b0;
      check_frame("ovf");
      n_checks++;
      if ({overflow, ft245_empty} !== 2'b11)
         $display("FAIL ovf_sticky: got ovf=%b empty=%b, expected 1 1", overflow, ft245_empty);
      else
         n_pass++;
      do_reset();
      n_checks++;
      if (overflow !== 1'b0)
         $display("FAIL ovf_clear: got %b, expected 0", overflow);
      else
         n_pass++;
   endtask

   task automatic test_gap();
      do_reset();
      txe_n = 1'b0;
      push_word(16'h0102);
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i >= 4) begin
            n_checks++;
            if (wr_n !== 1'b1)
               $display("FAIL gap_wrn%0d: got %b, expected 1", i, wr_n);
            else
               n_pass++;
         end
      end
      n_checks++;
      if (got_q.size() !== 3)
         $display("FAIL gap_count: got %0d bytes, expected 3", got_q.size());
      else
         n_pass++;
      push_word(16'h0304);
      push_word(16'h0506);
      push_word(16'h0708);
      check_frame("gap");
   endtask

   task automatic test_reset_mid();
      do_reset();
      txe_n = 1'b0;
      push_frame();
      wait_bytes(3, "rstmid_pre");
      rst_n = 1'b0;
      step();
      n_checks++;
      if ({wr_n, ft245_empty, ft_data} !== {1'b1, 1'b1, 8'h00})
         $display("FAIL rstmid_vals: got wr_n=%b empty=%b ft_data=%h, expected 1 1 00",
                  wr_n, ft245_empty, ft_data);
      else
         n_pass++;
      n_checks++;
      if (got_q.size() !== 3)
         $display("FAIL rstmid_count: got %0d bytes, expected 3", got_q.size());
      else
         n_pass++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      n_checks++;
      if ({wr_n, ft245_empty} !== 2'b11)
         $display("FAIL rstmid_discard: got wr_n=%b empty=%b, expected 1 1", wr_n, ft245_empty);
      else
         n_pass++;
      got_q.delete();
      push_frame();
      check_frame("rstmid");
   endtask

   task automatic test_checksum();
      logic [7:0] exp_b;
      do_reset();
      txe_n = 1'b0;
      push_frame();
      check_frame("csum");
`ifdef FT245_CHECKSUM_EN
      exp_b = 8'h08;
`else
      exp_b = 8'hA5;
`endif
      n_checks++;
      if (got_q.size() < 10 || got_q[9] !== exp_b)
         $display("FAIL csum_byte9: got %h, expected %h",
                  (got_q.size() < 10) ? 8'hxx : got_q[9], exp_b);
      else
         n_pass++;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 16'h0000;
      txe_n    = 1'b1;
      build_exp();
      test_reset();
      test_basic();
      test_stall();
      test_overflow();
      test_gap();
      test_reset_mid();
      test_checksum();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
